// File: rtl/timer_countdown_chain_pkg.sv
// Shared types for the countdown chain: digit field width, FSM states, load saturation.
package timer_countdown_chain_pkg;
    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Clamp an out-of-range start digit to the largest legal value for its modulus.
    function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] v,
                                                     input logic [DIGIT_W-1:0] m);
        return (v >= m) ? m - DIGIT_W'(1) : v;
    endfunction
endpackage

// File: rtl/timer_countdown_chain_if.sv
// Control/status bundle between the controller and the countdown chain.
interface timer_countdown_chain_if #(parameter int DIGITS = 4);
    import timer_countdown_chain_pkg::*;

    logic                             load;
    logic [DIGITS-1:0][DIGIT_W-1:0]   load_value;
    logic                             start;
    logic                             pause;
    logic                             tick;
    logic                             auto_reload;
    logic [DIGITS-1:0][DIGIT_W-1:0]   count;
    logic                             running;
    logic                             zero;
    logic                             done;

    modport master (
        output load, load_value, start, pause, tick, auto_reload,
        input  count, running, zero, done
    );
    modport slave (
        input  load, load_value, start, pause, tick, auto_reload,
        output count, running, zero, done
    );
endinterface

// File: rtl/timer_countdown_chain_digit.sv
// One modulo-MOD down-counting digit; borrow ripples combinationally to the next digit.
module timer_digit
    import timer_countdown_chain_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               ld,
    input  logic [DIGIT_W-1:0] ld_val,
    input  logic               en,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] q,
    output logic               borrow_out
);
    assign borrow_out = borrow_in & (q == '0);

    always_ff @(posedge clk or posedge clear) begin
        if (clear)
            q <= '0;
        else if (ld)
            q <= ld_val;
        else if (en && borrow_in)
            q <= (q == '0) ? DIGIT_W'(MOD - 1) : q - DIGIT_W'(1);
    end
endmodule

// File: rtl/timer_countdown_chain.sv
// Multi-digit countdown timer: digit cells plus run/pause/done FSM and auto-reload value.
module timer_countdown_chain
    import timer_countdown_chain_pkg::*;
#(
    parameter int                      DIGITS = 4,
    parameter logic [4*DIGITS-1:0]     MODS   = 16'h6A6A
) (
    input  logic                  clk,
    input  logic                  clear,
    timer_countdown_chain_if.slave bus
);
    state_t                          state, state_nxt;
    logic [DIGITS-1:0][DIGIT_W-1:0]  q, sat_val, reload_reg, ld_val;
    logic [DIGITS:0]                 borrow;
    logic                            tick_run, reload, ld, done_nxt, done_r;
    logic                            zero_w, at_one;

    assign zero_w    = (q == '0);
    assign at_one    = (q == (DIGITS*DIGIT_W)'(1));
    assign borrow[0] = tick_run;
    assign ld        = bus.load | reload;
    assign ld_val    = bus.load ? sat_val : reload_reg;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        localparam logic [DIGIT_W-1:0] MOD = MODS[DIGIT_W*i +: DIGIT_W];

        assign sat_val[i] = sat_digit(bus.load_value[i], MOD);

        timer_digit #(.MOD(int'(MOD))) u_digit (
            .clk        (clk),
            .clear      (clear),
            .ld         (ld),
            .ld_val     (ld_val[i]),
            .en         (tick_run),
            .borrow_in  (borrow[i]),
            .q          (q[i]),
            .borrow_out (borrow[i+1])
        );
    end

    // Priority: load > pause > start > tick; a tick only acts in RUN with no transition pending.
    always_comb begin
        state_nxt = state;
        tick_run  = 1'b0;
        reload    = 1'b0;
        done_nxt  = 1'b0;
        if (bus.load) begin
            state_nxt = IDLE;
        end else if (bus.pause) begin
            if (state == RUN) state_nxt = PAUSE;
        end else if (bus.start && state != RUN) begin
            if (!zero_w) state_nxt = RUN;
        end else if (bus.tick && state == RUN) begin
            if (zero_w) begin
                if (bus.auto_reload && reload_reg != '0) reload = 1'b1;
                else                                      state_nxt = DONE;
            end else begin
                tick_run = 1'b1;
                if (at_one) begin
                    done_nxt = 1'b1;
                    if (!bus.auto_reload) state_nxt = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state      <= IDLE;
            reload_reg <= '0;
            done_r     <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= done_nxt;
            if (bus.load) reload_reg <= sat_val;
        end
    end

    assign bus.count   = q;
    assign bus.running = (state == RUN);
    assign bus.zero    = zero_w;
    assign bus.done    = done_r;
endmodule

// File: tb/tb_timer_countdown_chain.sv
// Directed checks of load saturation, countdown, done pulse, auto-reload, pause and async clear.
module tb_timer_countdown_chain;
    logic clk = 1'b0;
    logic clear;
    int   n_chk = 0;
    int   n_pass = 0;

    timer_countdown_chain_if #(.DIGITS(4)) bus ();

    timer_countdown_chain #(.DIGITS(4), .MODS(16'h6A6A)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load = 1'b1; bus.load_value = v;
        cyc();
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
    endtask

    initial begin
        clear = 1'b1;
        bus.load = 1'b0; bus.load_value = '0; bus.start = 1'b0;
        bus.pause = 1'b0; bus.tick = 1'b0; bus.auto_reload = 1'b0;
        #12;
        chk("rst_count", 32'(bus.count), 32'h0000);
        chk("rst_running", 32'(bus.running), 0);
        chk("rst_zero", 32'(bus.zero), 1);
        chk("rst_done", 32'(bus.done), 0);
        clear = 1'b0;
        cyc();

        // 1: borrow ripple across two digits
        do_load(16'h0100); do_start(); do_tick();
        chk("t1_count", 32'(bus.count), 32'h0059);
        chk("t1_running", 32'(bus.running), 1);
        chk("t1_done", 32'(bus.done), 0);
        chk("t1_zero", 32'(bus.zero), 0);

        // 2: terminal count without reload
        do_load(16'h0002); do_start(); do_tick();
        chk("t2_count1", 32'(bus.count), 32'h0001);
        do_tick();
        chk("t2_count0", 32'(bus.count), 32'h0000);
        chk("t2_done", 32'(bus.done), 1);
        chk("t2_running", 32'(bus.running), 0);
        chk("t2_zero", 32'(bus.zero), 1);
        cyc();
        chk("t2_done_gone", 32'(bus.done), 0);
        do_tick();
        chk("t2_hold", 32'(bus.count), 32'h0000);
        chk("t2_no_pulse", 32'(bus.done), 0);
        do_start();
        chk("t2_start_zero", 32'(bus.running), 0);

        // 3: auto-reload, two periods
        bus.auto_reload = 1'b1;
        do_load(16'h0002); do_start(); do_tick();
        chk("t3_count1", 32'(bus.count), 32'h0001);
        do_tick();
        chk("t3_count0", 32'(bus.count), 32'h0000);
        chk("t3_done1", 32'(bus.done), 1);
        chk("t3_running", 32'(bus.running), 1);
        do_tick();
        chk("t3_reload", 32'(bus.count), 32'h0002);
        chk("t3_done_gone", 32'(bus.done), 0);
        chk("t3_running2", 32'(bus.running), 1);
        do_tick(); do_tick();
        chk("t3_count0b", 32'(bus.count), 32'h0000);
        chk("t3_done2", 32'(bus.done), 1);
        bus.auto_reload = 1'b0;

        // 4: per-digit saturation on load
        do_load(16'h9F9F);
        chk("t4_count", 32'(bus.count), 32'h5959);
        chk("t4_reload", 32'(dut.reload_reg), 32'h5959);
        chk("t4_idle", 32'(bus.running), 0);

        // 5: pause beats start; start+tick from PAUSE ignores the tick
        do_load(16'h0030); do_start();
        chk("t5_run", 32'(bus.running), 1);
        bus.start = 1'b1; bus.pause = 1'b1;
        cyc();
        bus.start = 1'b0; bus.pause = 1'b0;
        chk("t5_paused", 32'(bus.running), 0);
        do_tick(); do_tick();
        chk("t5_hold", 32'(bus.count), 32'h0030);
        bus.start = 1'b1; bus.tick = 1'b1;
        cyc();
        bus.start = 1'b0; bus.tick = 1'b0;
        chk("t5_resume", 32'(bus.running), 1);
        chk("t5_tick_ign", 32'(bus.count), 32'h0030);
        do_tick();
        chk("t5_count", 32'(bus.count), 32'h0029);

        // 6: asynchronous clear mid-run
        do_load(16'h1234); do_start(); do_tick();
        chk("t6_count", 32'(bus.count), 32'h1233);
        #2 clear = 1'b1;
        #1;
        chk("t6_clr_count", 32'(bus.count), 32'h0000);
        chk("t6_clr_running", 32'(bus.running), 0);
        chk("t6_clr_zero", 32'(bus.zero), 1);
        #2 clear = 1'b0;
        cyc();
        chk("t6_no_done", 32'(bus.done), 0);
        chk("t6_stay0", 32'(bus.count), 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
